mouse_input_conditioner: RTL
============================

// Module: mouse_input_conditioner
// PURPOSE
//  Parametrised mouse front-end between the PS/2 mouse controller and the pixel pipeline.
//  Re-times position and button inputs into the pclk domain and rejects torn multi-bit position samples.
//  Clamps the position to the visible screen, debounces each button, and emits press/release/moved strobes.
//  Downstream drawing and game logic consume only its registered outputs.
// PARAMETERS
//  W            12   width of xpos/ypos buses
//  SYNC_STAGES  2    synchroniser flops per input bit; legal range >=1
//  X_MAX        799  largest legal xpos_out; larger values are clamped to this
//  Y_MAX        599  largest legal ypos_out; larger values are clamped to this
//  NBTN         3    button count; bit0=left, bit1=right, bit2=middle
//  DEB_CYCLES   4    consecutive differing cycles before a button output toggles; legal range 1..255
// PORTS
//  pclk         in   1     pixel clock; all logic is clocked on its rising edge
//  rst          in   1     synchronous, active-high reset
//  xpos_in      in   W     raw x position from the mouse controller (asynchronous to pclk)
//  ypos_in      in   W     raw y position from the mouse controller (asynchronous to pclk)
//  btn_in       in   NBTN  raw button levels
//  xpos_out     out  W     conditioned x, always <= X_MAX
//  ypos_out     out  W     conditioned y, always <= Y_MAX
//  btn_out      out  NBTN  debounced button levels
//  btn_press    out  NBTN  1-cycle pulse on each 0->1 transition of btn_out
//  btn_release  out  NBTN  1-cycle pulse on each 1->0 transition of btn_out
//  moved        out  1     1-cycle pulse when xpos_out or ypos_out changes value
// BEHAVIOUR
//  Reset: rst is synchronous, active-high; clock is pclk.
//   - On reset, every sync flop, the prev register, all counters and all outputs are cleared to 0.
//   - No strobe is asserted during reset or on the first edge after reset deasserts.
//  Synchroniser: each bit of xpos_in, ypos_in and btn_in passes through SYNC_STAGES flops (syn_*).
//  Coherence filter:
//   - Register prev <= {syn_x, syn_y} every cycle.
//   - A sample is accepted only when {syn_x, syn_y} == prev, i.e. stable for 2 consecutive cycles.
//   - x and y are accepted jointly; when the sample is not accepted, the outputs hold.
//  Clamp: unsigned compare; cx = (syn_x > X_MAX) ? X_MAX : syn_x; cy is formed the same way with Y_MAX.
//  Position update:
//   - On acceptance, xpos_out <= cx and ypos_out <= cy.
//   - In the same edge, moved <= ({cx,cy} != {xpos_out,ypos_out}); otherwise moved <= 0.
//  Latency: once an input holds a new value, xpos_out/ypos_out update on the (SYNC_STAGES+2)th edge.
//   - Edge 1 is the first edge that samples the new value.
//   - With SYNC_STAGES=2 this is edge 4; moved is high during the cycle after that edge.
//  Clamp boundaries:
//   - Input == X_MAX passes through unchanged.
//   - Any input that clamps to the current output gives no moved pulse.
//  Button debouncer, one instance per bit with an 8-bit counter cnt:
//   - If syn_b == btn_out: cnt <= 0.
//   - Else if cnt == DEB_CYCLES-1: btn_out <= syn_b and cnt <= 0.
//   - Else: cnt <= cnt+1.
//   - Any glitch back to the btn_out level restarts the count.
//   - DEB_CYCLES=1 means btn_out follows syn_b with 1 cycle delay.
//  Strobes: btn_press and btn_release are registered on the same edge btn_out changes, high for exactly 1 cycle.
//   - Buttons are fully independent; simultaneous events on different bits pulse in the same cycle.
//  Reset mid-operation:
//   - A partial debounce count or a pending position is discarded; no strobe results.
//   - After reset, if btn_in is held high, a normal press is produced after the sync + debounce delay.
// STRUCTURE
//  Shared package mouse_pkg:
//   - MOUSE_W=12, SCREEN_X_MAX=799, SCREEN_Y_MAX=599, BTN_LEFT/RIGHT/MIDDLE bit indices.
//   - The top level passes these as parameter overrides.
//  Sub-module btn_debounce (params DEB_CYCLES; ports pclk, rst, b_in, b_out, press, release).
//   - Instantiated NBTN times with a generate loop.
//   - The synchroniser is an inline generate shift chain, not a separate module.
// TESTING (defaults unless stated)
//  1 Reset: rst high 3 cycles with xpos_in=100, ypos_in=50.
//    -> All outputs 0 and no strobes during reset.
//    -> After release, xpos_out=100 and ypos_out=50 appear on edge 4; moved high for exactly 1 cycle.
//  2 Clamp: xpos_in=1000, ypos_in=700 -> xpos_out=799, ypos_out=599.
//    -> Then xpos_in=1001 -> no moved pulse; then xpos_in=799 -> no moved pulse.
//  3 Tearing: xpos_in alternates 10/20 every cycle for 20 cycles -> xpos_out never changes.
//    -> Then hold 20 -> xpos_out=20 on edge 4 after the hold begins; moved fires once.
//  4 Bounce on btn_in[0]: 1 for 3 cycles, 0 for 1 cycle, then 1 held.
//    -> btn_out[0] stays 0 through the bounce.
//    -> It rises on the 4th consecutive differing cycle of syn_b, i.e. edge 2+4 after the final rise.
//    -> btn_press[0] pulses once; no release pulse.
//  5 Simultaneous: btn_out[1]=0 and btn_out[2]=1; btn_in[1] rises and btn_in[2] falls in the same cycle.
//    -> btn_press[1] and btn_release[2] pulse in the same single cycle.
//  6 Reset mid-debounce: btn_in[0]=1 until cnt=2, then rst for 1 cycle with btn_in[0] returned to 0.
//    -> btn_out[0]=0 and no press pulse ever occurs.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared mouse constants: bus width, visible screen limits and button bit positions.
package mouse_pkg;

    localparam int MOUSE_W      = 12;
    localparam int SCREEN_X_MAX = 799;
    localparam int SCREEN_Y_MAX = 599;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_MIDDLE = 2;

    typedef logic [MOUSE_W-1:0] coord_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: output toggles after DEB_CYCLES consecutive cycles of disagreement,
// with one-cycle press/release strobes registered on the toggling edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic pclk,
    input  logic rst,
    input  logic b_in,
    output logic b_out,
    output logic press,
    output logic rel
);

    logic [7:0] cnt_reg;
    logic       b_out_reg;
    logic       press_reg;
    logic       rel_reg;

    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_reg   <= '0;
            b_out_reg <= 1'b0;
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
            // Any cycle agreeing with the current level restarts the count.
            if (b_in == b_out_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == 8'(DEB_CYCLES - 1)) begin
                b_out_reg <= b_in;
                cnt_reg   <= '0;
                press_reg <= b_in;
                rel_reg   <= ~b_in;
            end else begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign b_out = b_out_reg;
    assign press = press_reg;
    assign rel   = rel_reg;

endmodule

// File: rtl/mouse_input_conditioner.sv
// Mouse front-end: synchronises position/buttons into pclk, drops torn position samples,
// clamps to the screen and debounces buttons with press/release/moved strobes.
module mouse_input_conditioner
    import mouse_pkg::*;
#(
    parameter int W           = MOUSE_W,
    parameter int SYNC_STAGES = 2,
    parameter int X_MAX       = SCREEN_X_MAX,
    parameter int Y_MAX       = SCREEN_Y_MAX,
    parameter int NBTN        = 3,
    parameter int DEB_CYCLES  = 4
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic [W-1:0]    xpos_in,
    input  logic [W-1:0]    ypos_in,
    input  logic [NBTN-1:0] btn_in,
    output logic [W-1:0]    xpos_out,
    output logic [W-1:0]    ypos_out,
    output logic [NBTN-1:0] btn_out,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic            moved
);

    localparam int SW = 2 * W + NBTN;
    localparam logic [W-1:0] X_LIM = W'(X_MAX);
    localparam logic [W-1:0] Y_LIM = W'(Y_MAX);

    logic [SW-1:0]   sync_reg [SYNC_STAGES];
    logic [2*W-1:0]  prev_reg;
    logic [W-1:0]    xpos_reg;
    logic [W-1:0]    ypos_reg;
    logic            moved_reg;

    logic [W-1:0]    syn_x;
    logic [W-1:0]    syn_y;
    logic [NBTN-1:0] syn_b;
    logic [W-1:0]    cx;
    logic [W-1:0]    cy;
    logic            accept;

    // All input bits share one shift chain; the last stage is the pclk-domain view.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= {xpos_in, ypos_in, btn_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign syn_x = sync_reg[SYNC_STAGES-1][SW-1 -: W];
    assign syn_y = sync_reg[SYNC_STAGES-1][NBTN +: W];
    assign syn_b = sync_reg[SYNC_STAGES-1][NBTN-1:0];

    // A multi-bit sample is only trusted once it has been identical on two consecutive cycles.
    assign accept = ({syn_x, syn_y} == prev_reg);
    assign cx     = (syn_x > X_LIM) ? X_LIM : syn_x;
    assign cy     = (syn_y > Y_LIM) ? Y_LIM : syn_y;

    always_ff @(posedge pclk) begin
        if (rst) begin
            prev_reg  <= '0;
            xpos_reg  <= '0;
            ypos_reg  <= '0;
            moved_reg <= 1'b0;
        end else begin
            prev_reg  <= {syn_x, syn_y};
            moved_reg <= 1'b0;
            if (accept) begin
                xpos_reg  <= cx;
                ypos_reg  <= cy;
                moved_reg <= ({cx, cy} != {xpos_reg, ypos_reg});
            end
        end
    end

    assign xpos_out = xpos_reg;
    assign ypos_out = ypos_reg;
    assign moved    = moved_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .pclk  (pclk),
                .rst   (rst),
                .b_in  (syn_b[gi]),
                .b_out (btn_out[gi]),
                .press (btn_press[gi]),
                .rel   (btn_release[gi])
            );
        end
    endgenerate

endmodule
